ones_cnt_datapath: RTL and testbench
====================================

ONES_CNT_DATAPATH -- requirements
Module: ones_cnt_datapath

Interface
REQ-001 Parameter: W, default 8, width of data operand R1.
REQ-002 Parameter: CW, default $clog2(W+1), width of count register R2 and result.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 data_in  input  W  operand to be counted, sampled on load_regs.
REQ-006 load_regs  input  1  from controller: load R1, preset R2.
REQ-007 incr_r2  input  1  from controller: increment R2.
REQ-008 shift  input  1  from controller: shift R1 left, MSB into E.
REQ-009 rdy  input  1  from controller: controller idle.
REQ-010 zero  output  1  status to controller: R1 equals 0.
REQ-011 E  output  1  status to controller: last bit shifted out of R1.
REQ-012 count  output  CW  captured ones-count result.
REQ-013 done  output  1  one-cycle pulse: count updated.
REQ-014 busy  output  1  an operation is in progress since last load.

Function
REQ-015 Registers: R1 (W bits), R2 (CW bits), E (1 bit), count (CW bits), busy, done.
REQ-016 load_regs=1: R1 <= data_in, R2 <= all ones, E <= 0, busy <= 1, next cycle.
REQ-017 shift=1 (load_regs=0): {E, R1} <= {R1, 1'b0}, i.e. E <= R1[W-1], R1 <= R1 << 1.
REQ-018 incr_r2=1 (load_regs=0): R2 <= R2 + 1 modulo 2^CW; all-ones + 1 wraps to 0 (intended first-increment behaviour).
REQ-019 shift and incr_r2 asserted together: both act in the same cycle, independently.
REQ-020 load_regs has priority over shift and incr_r2 in the same cycle; they are ignored.
REQ-021 No control asserted: R1, R2, E hold.
REQ-022 zero is combinational: zero = (R1 == 0); no added latency.
REQ-023 E output is the E register directly.
REQ-024 Capture: when busy=1 and rdy=1 and load_regs=0 in a cycle, next edge count <= R2, done <= 1, busy <= 0.
REQ-025 done is high exactly one cycle per capture; otherwise 0.
REQ-026 rdy=1 while busy=0: no capture, count holds, done stays 0.
REQ-027 load_regs while busy=1 (restart): R1/R2 reload, busy stays 1, no capture that cycle, count holds old value.
REQ-028 load_regs and rdy both high with busy=1: load wins, no capture.
REQ-029 count holds its value until the next capture; it is never partially updated.
REQ-030 Expected protocol with the one-hot controller: load -> incr -> (zero ? idle : shift -> E ? incr : shift ...); after completion R2 equals popcount(data_in).

Reset
REQ-031 rst=1 asynchronously forces: R1=0, R2=0, E=0, count=0, busy=0, done=0; thus zero=1 during and after reset.
REQ-032 rst asserted mid-operation aborts it: no capture, done=0, count=0.
REQ-033 After rst deasserts, first active edge behaves per REQ-016..REQ-028.

Verification
REQ-034 data_in=8'b1011_0010, drive full controller sequence -> done pulse one cycle, count=4, busy=0.
REQ-035 data_in=8'h00, load then one incr_r2, rdy -> R2 wraps 15->0, zero=1, count=0, done pulses.
REQ-036 data_in=8'hFF, full sequence -> count=8 (no overflow at CW=4), E=1 after each shift.
REQ-037 Assert shift and incr_r2 together from R1=8'h80, R2=4'h3 -> E=1, R1=0, zero=1, R2=4 next cycle; load_regs with both -> load only.
REQ-038 rst pulsed after 3 shifts with busy=1 -> immediate R1=0, E=0, busy=0, count=0, done=0; subsequent rdy produces no done.
REQ-039 Restart: load 8'h0F, partial run, load 8'h03 before rdy -> final count=2, exactly one done pulse.

Source files
------------

// File: rtl/ones_cnt_datapath_if.sv
// Handshake bundle between the ones-count controller and its datapath.
// The controller side drives the operand and the control strobes; the
// datapath side returns status bits and the captured result.
interface ones_cnt_datapath_if #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) ();

  logic [W-1:0]  data_in;
  logic          load_regs;
  logic          incr_r2;
  logic          shift;
  logic          rdy;

  logic          zero;
  logic          E;
  logic [CW-1:0] count;
  logic          done;
  logic          busy;

  // Controller (or testbench) side.
  modport master (
    output data_in, load_regs, incr_r2, shift, rdy,
    input  zero, E, count, done, busy
  );

  // Datapath side.
  modport slave (
    input  data_in, load_regs, incr_r2, shift, rdy,
    output zero, E, count, done, busy
  );

endinterface

// File: rtl/ones_cnt_datapath.sv
// Ones-count datapath. R1 holds the operand and is shifted left one bit at a
// time into E; R2 counts the ones seen. R2 is preset to all ones on load so
// the controller's unconditional first increment wraps it to zero. When the
// controller reports idle (rdy) during an operation, R2 is captured into the
// count output and done pulses for one cycle.
module ones_cnt_datapath #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  ones_cnt_datapath_if.slave   bus
);

  logic [W-1:0]  r1_q,    r1_d;
  logic [CW-1:0] r2_q,    r2_d;
  logic          e_q,     e_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  logic          capture;

  // A capture needs an operation in flight and an idle controller; a load in
  // the same cycle is a restart and takes precedence.
  assign capture = busy_q && bus.rdy && !bus.load_regs;

  // Operand, counter and shift-out bit: load overrides shift and increment,
  // which are independent of each other when both are asserted.
  always_comb begin
    r1_d = r1_q;
    r2_d = r2_q;
    e_d  = e_q;
    if (bus.load_regs) begin
      r1_d = bus.data_in;
      r2_d = '1;
      e_d  = 1'b0;
    end else begin
      if (bus.shift) begin
        e_d  = r1_q[W-1];
        r1_d = {r1_q[W-2:0], 1'b0};
      end
      // Wraps modulo 2^CW; the all-ones preset plus one lands on zero.
      if (bus.incr_r2) begin
        r2_d = r2_q + 1'b1;
      end
    end
  end

  // Result capture and operation status; count only changes on a capture.
  always_comb begin
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (bus.load_regs) begin
      busy_d = 1'b1;
    end else if (capture) begin
      count_d = r2_q;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, regardless of statement order.
    if (rst) begin
      r1_q    <= '0;
      r2_q    <= '0;
      e_q     <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      e_q     <= e_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Status back to the controller; zero is combinational on R1.
  assign bus.zero  = (r1_q == '0);
  assign bus.E     = e_q;
  assign bus.count = count_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_ones_cnt_datapath.sv
// Self-checking bench for ones_cnt_datapath: directed scenarios plus random
// operands, each run through the controller protocol and checked against a
// simple shift/popcount reference model.
module tb_ones_cnt_datapath;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;

  ones_cnt_datapath_if #(.W(W), .CW(CW)) bus ();

  ones_cnt_datapath #(.W(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One clock: drive controls, wait for the edge, sample 1 ns later.
  task automatic cycle(input logic ld, input logic inc, input logic sh,
                       input logic r, input logic [W-1:0] d);
    bus.load_regs = ld;
    bus.incr_r2   = inc;
    bus.shift     = sh;
    bus.rdy       = r;
    bus.data_in   = d;
    @(posedge clk);
    #1;
    if (bus.done === 1'b1) done_seen++;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Behaves like the one-hot controller: load, incr, then shift until R1 is
  // zero, incrementing whenever a one falls out into E, then go idle.
  task automatic run_ops(input logic [W-1:0] d, input string tag);
    int          guard;
    logic [W-1:0] m_r1;
    logic         m_e;
    m_r1 = d;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, d);
    check({tag, "_load_busy"}, 32'(bus.busy), 1);
    check({tag, "_load_zero"}, 32'(bus.zero), 32'(d == 0));
    check({tag, "_load_e"},    32'(bus.E), 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    guard = 0;
    while (bus.zero !== 1'b1 && guard < 2 * W) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
      m_e  = m_r1[W-1];
      m_r1 = m_r1 * 2;
      check({tag, "_shift_e"},    32'(bus.E), 32'(m_e));
      check({tag, "_shift_zero"}, 32'(bus.zero), 32'(m_r1 == 0));
      if (bus.E === 1'b1) cycle(1'b0, 1'b1, 1'b0, 0, '0);
      guard++;
    end
    check({tag, "_terminated"}, 32'(bus.zero), 1);
  endtask

  // Idle phase: rdy twice; capture on the first, hold on the second.
  task automatic finish_ops(input int exp_count, input string tag);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check({tag, "_done"},  32'(bus.done), 1);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_count"}, 32'(bus.count), 32'(exp_count));
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check({tag, "_done_clr"},   32'(bus.done), 0);
    check({tag, "_count_hold"}, 32'(bus.count), 32'(exp_count));
  endtask

  initial begin
    logic [W-1:0] d;
    int           prev;

    rst           = 1'b1;
    bus.load_regs = 1'b0;
    bus.incr_r2   = 1'b0;
    bus.shift     = 1'b0;
    bus.rdy       = 1'b0;
    bus.data_in   = '0;
    #12;
    check("rst_zero",  32'(bus.zero), 1);
    check("rst_e",     32'(bus.E), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_done",  32'(bus.done), 0);
    check("rst_busy",  32'(bus.busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // rdy while not busy: no capture.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("idle_rdy_done",  32'(bus.done), 0);
    check("idle_rdy_count", 32'(bus.count), 0);

    // Mixed operand, all-zero operand (first increment wraps), all-ones.
    done_seen = 0;
    run_ops(8'b1011_0010, "b2");
    finish_ops(4, "b2");
    check("b2_one_pulse", 32'(done_seen), 1);
    done_seen = 0;
    run_ops(8'h00, "z");
    finish_ops(0, "z");
    check("z_one_pulse", 32'(done_seen), 1);
    run_ops(8'hFF, "ff");
    finish_ops(8, "ff");

    // Shift and increment together from R1=0x80, R2=3.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h80);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("both_e",    32'(bus.E), 1);
    check("both_zero", 32'(bus.zero), 1);
    finish_ops(4, "both");
    // Load with shift and incr asserted: load only.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h40);
    check("ldpri_e",    32'(bus.E), 0);
    check("ldpri_zero", 32'(bus.zero), 0);
    check("ldpri_busy", 32'(bus.busy), 1);
    finish_ops(15, "ldpri");

    // Asynchronous reset mid-operation, applied away from a clock edge.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'b1011_0010);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("pre_rst_busy", 32'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_zero",  32'(bus.zero), 1);
    check("arst_e",     32'(bus.E), 0);
    check("arst_busy",  32'(bus.busy), 0);
    check("arst_count", 32'(bus.count), 0);
    check("arst_done",  32'(bus.done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    done_seen = 0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("post_rst_no_done", 32'(done_seen), 0);
    check("post_rst_count",   32'(bus.count), 0);

    // Restart: partial run on 0x0F, then reload 0x03 together with rdy.
    prev      = 32'(bus.count);
    done_seen = 0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h0F);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h03);
    check("restart_done",  32'(bus.done), 0);
    check("restart_busy",  32'(bus.busy), 1);
    check("restart_count", 32'(bus.count), 32'(prev));
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    begin
      int g = 0;
      while (bus.zero !== 1'b1 && g < 2 * W) begin
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
        if (bus.E === 1'b1) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
        g++;
      end
    end
    finish_ops(2, "restart");
    check("restart_one_pulse", 32'(done_seen), 1);

    // Random operands against the popcount reference.
    for (int i = 0; i < 24; i++) begin
      d         = W'($urandom_range(0, (1 << W) - 1));
      done_seen = 0;
      run_ops(d, "rnd");
      finish_ops($countones(d), "rnd");
      check("rnd_one_pulse", 32'(done_seen), 1);
      if ($urandom_range(0, 1) == 1) idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "simulation time bound reached");
  end

endmodule
